// File: rtl/stopwatch_6bit.sv
// Start/pause/clear stopwatch counting 0..MAX at one step per DIV clocks.
// Buttons are synchronized and edge-detected; carry pulses on each MAX->0 wrap.
module stopwatch_6bit #(
    parameter int unsigned DIV = 50_000_000,
    parameter int unsigned MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [5:0] count,
    output logic       running,
    output logic       carry
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [5:0] CNT_MAX = 6'(MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    count_q, count_d;
    logic          running_q, running_d;
    logic          carry_q, carry_d;

    logic start_meta_q, start_meta_d, start_sync_q, start_sync_d, start_prev_q, start_prev_d;
    logic clear_meta_q, clear_meta_d, clear_sync_q, clear_sync_d, clear_prev_q, clear_prev_d;
    logic start_evt, clear_evt, tick;

    // Two-flop synchronizers plus a history flop for rising-edge detection
    always_comb begin
        start_meta_d = btn_start;
        start_sync_d = start_meta_q;
        start_prev_d = start_sync_q;
        clear_meta_d = btn_clear;
        clear_sync_d = clear_meta_q;
        clear_prev_d = clear_sync_q;
        start_evt    = start_sync_q & ~start_prev_q;
        clear_evt    = clear_sync_q & ~clear_prev_q;
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        carry_d = 1'b0;
        tick    = (state_q == S_RUN) && (presc_q == PRE_LAST);

        if (state_q == S_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                count_d = (count_q >= CNT_MAX) ? 6'd0 : count_q + 6'd1;
                carry_d = (count_q >= CNT_MAX);
            end
        end

        // A start on a tick cycle still lets that tick land before pausing
        case (state_q)
            S_IDLE:  if (start_evt) state_d = S_RUN;
            S_RUN:   if (start_evt) state_d = S_PAUSE;
            S_PAUSE: if (start_evt) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        if (clear_evt) begin
            state_d = S_IDLE;
        end

        if (state_d == S_IDLE) begin
            presc_d = '0;
            count_d = 6'd0;
            carry_d = 1'b0;
        end

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            count_q      <= 6'd0;
            running_q    <= 1'b0;
            carry_q      <= 1'b0;
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_prev_q <= 1'b0;
            clear_meta_q <= 1'b0;
            clear_sync_q <= 1'b0;
            clear_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            count_q      <= count_d;
            running_q    <= running_d;
            carry_q      <= carry_d;
            start_meta_q <= start_meta_d;
            start_sync_q <= start_sync_d;
            start_prev_q <= start_prev_d;
            clear_meta_q <= clear_meta_d;
            clear_sync_q <= clear_sync_d;
            clear_prev_q <= clear_prev_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign carry   = carry_q;

endmodule

// File: tb/tb_stopwatch_6bit.sv
// Directed bench for stopwatch_6bit with DIV=4, MAX=59; expectations are hand-derived
// cycle counts from each button rise (event lands two edges after first capture).
module tb_stopwatch_6bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       btn_clear;
    logic [5:0] count;
    logic       running;
    logic       carry;

    int tests  = 0;
    int failed = 0;

    stopwatch_6bit #(.DIV(4), .MAX(59)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .count     (count),
        .running   (running),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input int r, input int k);
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_running"}, 32'(running), 32'(r));
        check({tag, "_carry"}, 32'(carry), 32'(k));
    endtask

    initial begin
        rst       = 1'b1;
        btn_start = 1'b0;
        btn_clear = 1'b0;

        // Reset held for three edges, then idle with buttons low
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_all("reset", 0, 0, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            check_all("idle", 0, 0, 0);
        end

        // Start: rise before edge 1, RUN at edge 3, first increment 4 edges later
        btn_start = 1'b1;
        step(2);
        check("start_lat_pre", 32'(running), 32'd0);
        step(1);
        check_all("start_lat", 0, 1, 0);
        step(2);
        btn_start = 1'b0;
        step(1);
        check("start_cnt0", 32'(count), 32'd0);
        step(1);
        check("start_cnt1", 32'(count), 32'd1);
        step(36);
        check("start_cnt10", 32'(count), 32'd10);

        // Run to 23 (tick just landed), then pause with a held button
        step(52);
        check_all("pre_pause", 23, 1, 0);
        btn_start = 1'b1;
        step(3);
        check_all("pause_enter", 23, 0, 0);
        for (int i = 1; i <= 100; i++) begin
            step(1);
            check("pause_run", 32'(running), 32'd0);
            check("pause_cnt", 32'(count), 32'd23);
            if (i == 47) btn_start = 1'b0;
        end

        // Resume: prescaler held at its last phase, so the tick comes right away
        btn_start = 1'b1;
        step(3);
        check_all("resume", 23, 1, 0);
        step(1);
        check_all("resume_tick", 24, 1, 0);
        btn_start = 1'b0;

        // Clear, then restart from zero for the wrap test
        btn_clear = 1'b1;
        step(3);
        check_all("clear", 0, 0, 0);
        btn_clear = 1'b0;
        btn_start = 1'b1;
        step(3);
        check_all("restart", 0, 1, 0);
        btn_start = 1'b0;
        for (int i = 1; i <= 364; i++) begin
            step(1);
            check("wrap_cnt", 32'(count), 32'((i / 4) % 60));
            check("wrap_carry", 32'(carry), (i == 240) ? 32'd1 : 32'd0);
        end

        // Simultaneous start and clear at count 31: clear wins
        btn_start = 1'b1;
        btn_clear = 1'b1;
        step(2);
        check_all("prio_pre", 31, 1, 0);
        step(1);
        check_all("prio", 0, 0, 0);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        step(5);
        check_all("prio_idle", 0, 0, 0);

        // Async reset mid-RUN at count 46, asserted between edges
        btn_start = 1'b1;
        step(3);
        check("ar_run", 32'(running), 32'd1);
        btn_start = 1'b0;
        step(184);
        check_all("ar_pre", 46, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all("ar_async", 0, 0, 0);
        btn_start = 1'b1;
        step(2);
        check_all("ar_hold", 0, 0, 0);

        // Button held across reset release registers as exactly one event
        rst = 1'b0;
        step(2);
        check("held_pre", 32'(running), 32'd0);
        step(1);
        check("held_run", 32'(running), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("held_single", 32'(running), 32'd1);
        end
        btn_start = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/stopwatch_6bit.md
STOPWATCH_6BIT -- requirements
Module: stopwatch_6bit

Interface
REQ-001 Parameter: DIV, default 50_000_000, clk cycles per count increment (>=2).
REQ-002 Parameter: MAX, default 59, terminal count value (1..63).
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: btn_start  input  1  start/pause button level, asynchronous to clk, active-high.
REQ-006 Port: btn_clear  input  1  clear button level, asynchronous to clk, active-high.
REQ-007 Port: count  output  6  current value, binary 0..MAX; drives the 6-bit data input of display_6bit directly.
REQ-008 Port: running  output  1  high while the FSM is in RUN.
REQ-009 Port: carry  output  1  one-cycle pulse on wrap MAX->0, for chaining a minutes stage.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, producing a one-cycle event (start_evt, clear_evt).
REQ-011 Button-to-action latency SHALL be fixed: an input rising before clk edge k takes effect in state/count at edge k+2.
REQ-012 A button held high for any number of cycles SHALL produce exactly one event; re-arming requires a low level seen by the synchronizer.
REQ-013 FSM states SHALL be IDLE, RUN, PAUSE; encoding is free.
REQ-014 Transitions: IDLE+start_evt->RUN; RUN+start_evt->PAUSE; PAUSE+start_evt->RUN; any state+clear_evt->IDLE.
REQ-015 clear_evt SHALL take priority over start_evt in the same cycle.
REQ-016 Entering IDLE SHALL zero count and the prescaler in the same edge.
REQ-017 Prescaler SHALL count 0..DIV-1 only in RUN; tick is high during the cycle the prescaler equals DIV-1, and the prescaler wraps to 0 on that edge.
REQ-018 In PAUSE the prescaler and count SHALL hold; resume continues from the held prescaler phase.
REQ-019 On each tick edge, count SHALL increment by 1; if count==MAX it SHALL become 0.
REQ-020 carry SHALL be registered, high for exactly one cycle beginning at the edge where count goes MAX->0; low otherwise.
REQ-021 A start_evt arriving on a tick cycle in RUN SHALL still apply that tick (count increments) and then enter PAUSE.
REQ-022 count SHALL never exceed MAX; all outputs are registered, no combinational path from inputs to outputs.

Reset
REQ-023 While rst is high: count=0, running=0, carry=0, FSM=IDLE, prescaler=0, synchronizer and edge-detect flops=0, asynchronously and independent of clk.
REQ-024 After rst deassertion a button already held high SHALL register as one event once synchronized (edge detector starts from 0).
REQ-025 rst asserted mid-RUN SHALL force all outputs to reset values immediately, with no carry pulse.

Verification (bench uses DIV=4, MAX=59)
REQ-026 Reset: rst=1 for 3 cycles then 0, buttons low 100 cycles -> count=0, running=0, carry=0 throughout.
REQ-027 Start: btn_start high 5 cycles -> running=1 at 3rd edge after rise; count=1 four cycles later, count=10 after 40 RUN cycles.
REQ-028 Held button / pause: btn_start held 50 cycles -> exactly one toggle; at count=23 press start -> running=0, count holds 23 for 100 cycles; press again -> resumes, count=24 after remaining prescaler cycles (<=4).
REQ-029 Wrap: run from 0 for 240 RUN cycles -> count passes 59 then 0; carry high exactly one cycle coincident with count=0; no carry elsewhere.
REQ-030 Priority: in RUN at count=31, btn_start and btn_clear rise same cycle -> IDLE, count=0, running=0, no PAUSE.
REQ-031 Async reset: assert rst between clk edges at count=46 in RUN -> count=0, running=0 before next clk edge.
